// File: rtl/aes_acc_pkg.sv
// Shared types and constants for the AES block sequencer.
package aes_acc_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int WORD_W      = 32;
    localparam int NUM_WORDS   = 4;
    localparam int ADDR_INC    = 4;
    localparam int WIDX_W      = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CIPHER,
        ST_WAIT,
        ST_WRITE,
        ST_FINISH
    } state_t;

    // Bit offset of word slot idx inside a block: word 0 is the most significant.
    function automatic int word_lsb(input int idx);
        return (NUM_WORDS - 1 - idx) * WORD_W;
    endfunction

endpackage

// File: rtl/aes_word_buffer.sv
// 4x32 block buffer: word writes while reading plaintext, a 128-bit parallel
// load for the AES result, and both 128-bit and word-indexed read views.
module aes_word_buffer
    import aes_acc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDX_W-1:0]      wr_idx,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   ld_en,
    input  logic [AES_BLOCK_W-1:0] ld_data,
    input  logic [WIDX_W-1:0]      rd_idx,
    output logic [WORD_W-1:0]      rd_data,
    output logic [AES_BLOCK_W-1:0] blk
);

    logic [WORD_W-1:0] mem [NUM_WORDS];

    // Storage update; a parallel load wins over a word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else if (ld_en) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= ld_data[word_lsb(i) +: WORD_W];
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read views: whole block and the currently indexed word.
    always_comb begin
        blk = '0;
        for (int i = 0; i < NUM_WORDS; i++) blk[word_lsb(i) +: WORD_W] = mem[i];
        rd_data = mem[rd_idx];
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Moves plaintext blocks from memory through the AES core and writes the
// ciphertext back, one 32-bit bus word at a time.
module aes_block_sequencer #(
    parameter int NB_W      = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic            hclk,
    input  logic            hrst,
    input  logic            start,
    input  logic [31:0]     src_addr,
    input  logic [31:0]     dst_addr,
    input  logic [NB_W-1:0] num_blocks,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            mst_req,
    output logic            mst_write,
    output logic [31:0]     mst_addr,
    output logic [31:0]     mst_wdata,
    input  logic            mst_ack,
    input  logic            mst_err,
    input  logic [31:0]     mst_rdata,
    output logic            aes_start,
    output logic [127:0]    aes_din,
    input  logic [127:0]    aes_dout,
    input  logic            aes_done
);

    import aes_acc_pkg::*;

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

    state_t            state, state_n;
    logic [31:0]       rd_ptr, wr_ptr;
    logic [NB_W-1:0]   blk_cnt;
    logic [WIDX_W-1:0] wcnt;
    logic              buf_wr, buf_ld;
    logic [WORD_W-1:0] buf_word;
    logic              good_ack, bad_ack;

    assign good_ack = mst_ack && !mst_err;
    assign bad_ack  = mst_ack &&  mst_err;

    aes_word_buffer u_buf (
        .clk     (hclk),
        .rst     (hrst),
        .wr_en   (buf_wr),
        .wr_idx  (wcnt),
        .wr_data (mst_rdata),
        .ld_en   (buf_ld),
        .ld_data (aes_dout),
        .rd_idx  (wcnt),
        .rd_data (buf_word),
        .blk     (aes_din)
    );

    // State register.
    always_ff @(posedge hclk) begin
        if (hrst) state <= ST_IDLE;
        else      state <= state_n;
    end

    // Next state and all state-decoded outputs.
    always_comb begin
        state_n   = state;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        mst_req   = 1'b0;
        mst_write = 1'b0;
        mst_addr  = '0;
        mst_wdata = '0;
        aes_start = 1'b0;
        buf_wr    = 1'b0;
        buf_ld    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_n = (num_blocks == '0) ? ST_FINISH : ST_READ;
            end
            ST_READ: begin
                mst_req  = 1'b1;
                mst_addr = rd_ptr;
                buf_wr   = good_ack;
                if (bad_ack)                            state_n = ST_FINISH;
                else if (good_ack && wcnt == LAST_WORD) state_n = ST_CIPHER;
            end
            ST_CIPHER: begin
                aes_start = 1'b1;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                buf_ld = aes_done;
                if (aes_done) state_n = ST_WRITE;
            end
            ST_WRITE: begin
                mst_req   = 1'b1;
                mst_write = 1'b1;
                mst_addr  = wr_ptr;
                mst_wdata = buf_word;
                if (bad_ack) state_n = ST_FINISH;
                else if (good_ack && wcnt == LAST_WORD)
                    state_n = (blk_cnt == NB_W'(1)) ? ST_FINISH : ST_READ;
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Job registers: pointers, word/block counters and the sticky error flag.
    // wcnt wraps to 0 on its own after the last word of a block.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            blk_cnt <= '0;
            wcnt    <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_ptr  <= src_addr;
                        wr_ptr  <= dst_addr;
                        blk_cnt <= num_blocks;
                        wcnt    <= '0;
                        error   <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (bad_ack) error <= 1'b1;
                    else if (good_ack) begin
                        rd_ptr <= rd_ptr + 32'(ADDR_INC);
                        wcnt   <= wcnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bad_ack) error <= 1'b1;
                    else if (good_ack) begin
                        wr_ptr <= wr_ptr + 32'(ADDR_INC);
                        wcnt   <= wcnt + 1'b1;
                        if (wcnt == LAST_WORD) blk_cnt <= blk_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed-plus-random bench: a memory/AES responder, a transaction logger and
// a job-level reference model that predicts every bus word and AES block.
module tb_aes_block_sequencer;

    localparam int NB_W = 16;

    logic            hclk = 1'b0;
    logic            hrst = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     src_addr = '0, dst_addr = '0;
    logic [NB_W-1:0] num_blocks = '0;
    logic            busy, done, error;
    logic            mst_req, mst_write;
    logic [31:0]     mst_addr, mst_wdata;
    logic            mst_ack = 1'b0, mst_err = 1'b0;
    logic [31:0]     mst_rdata = '0;
    logic            aes_start;
    logic [127:0]    aes_din;
    logic [127:0]    aes_dout = '0;
    logic            aes_done = 1'b0;

    aes_block_sequencer #(.NB_W(NB_W), .NUM_WORDS(4)) dut (
        .hclk(hclk), .hrst(hrst), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .num_blocks(num_blocks), .busy(busy), .done(done),
        .error(error), .mst_req(mst_req), .mst_write(mst_write),
        .mst_addr(mst_addr), .mst_wdata(mst_wdata), .mst_ack(mst_ack),
        .mst_err(mst_err), .mst_rdata(mst_rdata), .aes_start(aes_start),
        .aes_din(aes_din), .aes_dout(aes_dout), .aes_done(aes_done)
    );

    always #5 hclk = ~hclk;

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; int cyc; } txn_t;
    typedef struct { logic [127:0] din; int cyc; } ast_t;

    txn_t tl[$];
    ast_t al[$];
    int   dl[$];
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;

    // responder knobs (written only by the initial block)
    int aes_lat = 10, max_stall = 0, err_at = -1;
    // responder state
    int ack_n = 0, wait_cnt = 0, aes_due = 0;
    logic aes_pend = 1'b0;
    logic [127:0] aes_in = '0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] salt = 32'h1357_9BDF;

    // job results
    int t0, tb0, ab0, db0, done_rel, low_busy, req_cyc;
    logic err1, post_busy, post_done, post_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] x);
        return {x[95:0], x[127:96]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    always @(posedge hclk) cyc <= cyc + 1;

    // logger: completed transfers, AES starts, done pulses
    always @(posedge hclk) begin
        if (hrst) aes_pend <= 1'b0;
        else begin
            if (mst_req && mst_ack)
                tl.push_back('{mst_write, mst_addr, mst_write ? mst_wdata : mst_rdata, cyc});
            if (aes_start) begin
                al.push_back('{aes_din, cyc});
                aes_in   <= aes_din;
                aes_due  <= cyc + aes_lat;
                aes_pend <= 1'b1;
            end else if (aes_done) aes_pend <= 1'b0;
            if (done) dl.push_back(cyc);
        end
    end

    // bus slave with random stalls, and AES core with fixed latency
    always @(negedge hclk) begin
        if (hrst || !mst_req) begin
            mst_ack <= 1'b0;
            mst_err <= 1'b0;
        end else if (wait_cnt > 0) begin
            wait_cnt <= wait_cnt - 1;
            mst_ack  <= 1'b0;
            mst_err  <= 1'b0;
        end else begin
            mst_ack   <= 1'b1;
            mst_rdata <= mem_word(mst_addr);
            mst_err   <= (ack_n == err_at);
            ack_n     <= ack_n + 1;
            wait_cnt  <= (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        end
        aes_done <= aes_pend && (cyc == aes_due);
        aes_dout <= aes_model(aes_in);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a job at a negedge and waits (bounded) for its done pulse.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int nb,
                           input int lat, input int stall, input int e, input int inj);
        aes_lat = lat; max_stall = stall;
        err_at = (e < 0) ? -1 : ack_n + e;
        tb0 = tl.size(); ab0 = al.size(); db0 = dl.size();
        src_addr = s; dst_addr = d; num_blocks = NB_W'(nb); start = 1'b1; t0 = cyc;
        done_rel = -1; low_busy = 0; req_cyc = 0; err1 = 1'bx;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge hclk);
            start = (k == inj);
            if (k == inj) begin src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; num_blocks = 7; end
            if (k == 1) err1 = error;
            if (!busy) low_busy++;
            if (mst_req) req_cyc++;
            if (done) begin done_rel = k; break; end
        end
        start = 1'b0;
        chk("job_done_seen", 128'(done_rel >= 0), 128'(1));
        @(negedge hclk);
        post_busy = busy; post_done = done; post_err = error;
    endtask

    // Reference model: whole-job expectations from addresses, memory and AES model.
    task automatic check_job(input logic [31:0] s, input logic [31:0] d, input int nb, input int e);
        txn_t ex[$];
        logic [127:0] dx[$];
        logic [127:0] pt, ct;
        logic [31:0] a;
        int n_ast, n;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++) begin
                a = s + 32'(16 * b + 4 * i);
                pt[127 - 32 * i -: 32] = mem_word(a);
                ex.push_back('{1'b0, a, mem_word(a), 0});
            end
            dx.push_back(pt);
            ct = aes_model(pt);
            for (int i = 0; i < 4; i++)
                ex.push_back('{1'b1, d + 32'(16 * b + 4 * i), ct[127 - 32 * i -: 32], 0});
        end
        n_ast = nb;
        if (e >= 0) begin
            while (ex.size() > e + 1) void'(ex.pop_back());
            n_ast = 0;
            for (int b = 0; b < nb; b++) if (8 * b + 3 < e) n_ast++;
        end
        chk("txn_count", 128'(tl.size() - tb0), 128'(ex.size()));
        n = (tl.size() - tb0 < ex.size()) ? tl.size() - tb0 : ex.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("txn%0d_dir", i), 128'(tl[tb0 + i].wr), 128'(ex[i].wr));
            chk($sformatf("txn%0d_addr", i), 128'(tl[tb0 + i].addr), 128'(ex[i].addr));
            if (ex[i].wr) chk($sformatf("txn%0d_wdata", i), 128'(tl[tb0 + i].data), 128'(ex[i].data));
        end
        chk("aes_start_count", 128'(al.size() - ab0), 128'(n_ast));
        for (int i = 0; i < n_ast && ab0 + i < al.size(); i++)
            chk($sformatf("aes_din%0d", i), al[ab0 + i].din, dx[i]);
        chk("done_pulses", 128'(dl.size() - db0), 128'(1));
        chk("busy_gap", 128'(low_busy), 128'(0));
        chk("error_flag", 128'(post_err), 128'(e >= 0));
        chk("idle_after", 128'(post_busy), 128'(0));
        chk("done_single", 128'(post_done), 128'(0));
    endtask

    initial begin
        logic [31:0] rs, rd;
        int rn, hit;

        // reset state
        repeat (3) @(negedge hclk);
        chk("reset_outputs", {busy, done, error, mst_req, mst_write, mst_addr, mst_wdata, aes_start},
            128'(0));
        chk("reset_aes_din", aes_din, 128'(0));
        hrst = 1'b0;
        @(negedge hclk);

        // single block, known data, ack every cycle, L=10
        mem[32'h1000] = 32'h0011_2233; mem[32'h1004] = 32'h4455_6677;
        mem[32'h1008] = 32'h8899_AABB; mem[32'h100C] = 32'hCCDD_EEFF;
        run_job(32'h1000, 32'h2000, 1, 10, 0, -1, 0);
        check_job(32'h1000, 32'h2000, 1, -1);
        chk("t1_done_cycle", 128'(done_rel), 128'(20));
        if (al.size() > ab0) begin
            chk("t1_aes_din", al[ab0].din, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
            chk("t1_aes_start_cycle", 128'(al[ab0].cyc - t0), 128'(5));
        end
        if (tl.size() - tb0 == 8)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t1_rd%0d_cycle", i), 128'(tl[tb0 + i].cyc - t0), 128'(1 + i));
                chk($sformatf("t1_wr%0d_cycle", i), 128'(tl[tb0 + 4 + i].cyc - t0), 128'(16 + i));
            end

        // three blocks with random stalls
        run_job(32'h1000, 32'h2000, 3, 1 + int'($urandom_range(7)), 3, -1, 0);
        check_job(32'h1000, 32'h2000, 3, -1);

        // zero blocks: immediate done, no traffic
        run_job(32'h3000, 32'h4000, 0, 5, 0, -1, 0);
        check_job(32'h3000, 32'h4000, 0, -1);
        chk("nb0_done_cycle", 128'(done_rel), 128'(1));
        chk("nb0_no_req", 128'(req_cyc), 128'(0));

        // bus error on the second read ack
        run_job(32'h5000, 32'h6000, 2, 4, 1, 1, 0);
        check_job(32'h5000, 32'h6000, 2, 1);
        run_job(32'h5000, 32'h6000, 1, 4, 0, -1, 0);
        chk("error_cleared_by_start", 128'(err1), 128'(0));
        check_job(32'h5000, 32'h6000, 1, -1);

        // start pulse during WAIT is ignored
        run_job(32'h7000, 32'h8000, 2, 30, 0, -1, 12);
        check_job(32'h7000, 32'h8000, 2, -1);

        // reset during WRITE word 2, then a clean job
        aes_lat = 6; max_stall = 0; err_at = -1;
        src_addr = 32'h9000; dst_addr = 32'hA000; num_blocks = 2; start = 1'b1;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge hclk);
            start = 1'b0;
            if (mst_req && mst_write && mst_addr == 32'hA008) begin hit = 1; hrst = 1'b1; break; end
        end
        chk("rst_mid_reached", 128'(hit), 128'(1));
        @(negedge hclk);
        chk("rst_mid_outputs", {busy, done, error, mst_req, mst_write, mst_addr, mst_wdata, aes_start},
            128'(0));
        chk("rst_mid_aes_din", aes_din, 128'(0));
        hrst = 1'b0;
        @(negedge hclk);
        run_job(32'h9000, 32'hA000, 1, 3, 2, -1, 0);
        check_job(32'h9000, 32'hA000, 1, -1);

        // address wrap
        run_job(32'hFFFF_FFF8, 32'hFFFF_FFF0, 1, 2, 0, -1, 0);
        check_job(32'hFFFF_FFF8, 32'hFFFF_FFF0, 1, -1);
        if (tl.size() - tb0 >= 4) begin
            chk("wrap_rd2", 128'(tl[tb0 + 2].addr), 128'(32'h0000_0000));
            chk("wrap_rd3", 128'(tl[tb0 + 3].addr), 128'(32'h0000_0004));
        end

        // random jobs
        for (int j = 0; j < 4; j++) begin
            rs = {$urandom_range(32'hFFFF), 14'h0, 2'b00} ^ 32'(j * 16);
            rd = {$urandom_range(32'hFFFF), 16'h0};
            rn = 1 + int'($urandom_range(3));
            salt = $urandom;
            run_job(rs, rd, rn, 1 + int'($urandom_range(12)), int'($urandom_range(3)), -1, 0);
            check_job(rs, rd, rn, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_block_sequencer.md
Name: aes_block_sequencer

Overview:
Sequences AES block processing through the AHB master port.
- Fetches NUM_WORDS 32-bit words of plaintext starting at a source address and packs them into one 128-bit block.
- Starts the AES core, waits for its result, then writes the ciphertext words to a destination address.
- Repeats for the programmed number of blocks.
- Sits between the slave-side register file (config in, status out), the AHB master interface (word requests) and the AES core.

Parameters:
NB_W, 16, width of the block-count field (max 2^NB_W-1 blocks per job)
NUM_WORDS, 4, words per AES block (fixed at 4; the parameter exists for package consistency)

Ports:
hclk  in  1  clock
hrst  in  1  reset, synchronous, active-high
start  in  1  one-cycle job start pulse from the register file
src_addr  in  32  source byte address (word aligned)
dst_addr  in  32  destination byte address (word aligned)
num_blocks  in  NB_W  number of 128-bit blocks in the job
busy  out  1  high from the cycle after an accepted start until return to IDLE
done  out  1  one-cycle pulse at job end (success or error)
error  out  1  sticky bus error flag; cleared by the next accepted start
mst_req  out  1  word transfer request to the master interface
mst_write  out  1  1 = write, 0 = read; drives ahbMode
mst_addr  out  32  transfer address
mst_wdata  out  32  write data
mst_ack  in  1  transfer complete this cycle
mst_err  in  1  error response; qualified by mst_ack
mst_rdata  in  32  read data; valid with mst_ack on reads
aes_start  out  1  one-cycle pulse; aes_din is valid in that cycle
aes_din  out  128  block to the AES core
aes_dout  in  128  AES result; valid with aes_done
aes_done  in  1  one-cycle result-valid pulse

Behaviour:
Reset values:
- All outputs 0; FSM in IDLE; internal counters and registers 0.
- Reset overrides everything, including mid-transfer; mst_req drops in the cycle after hrst is sampled.

States: IDLE, READ, CIPHER, WAIT, WRITE, FINISH.
- IDLE: start latches src_addr, dst_addr and num_blocks and clears error.
  - num_blocks == 0 -> FINISH (done pulse one cycle later, no bus traffic).
  - otherwise -> READ.
  - start is ignored in every state other than IDLE.
- READ: mst_req=1, mst_write=0, mst_addr=rd_ptr.
  - Each mst_ack stores mst_rdata into word slot wcnt. Word 0 maps to aes_din[127:96]; word 3 maps to [31:0].
  - On each ack: rd_ptr += 4, wcnt += 1.
  - After the 4th ack -> CIPHER. mst_req stays high across back-to-back acks.
- CIPHER: aes_start=1 for exactly one cycle -> WAIT.
- WAIT: mst_req=0. aes_done latches aes_dout into the buffer -> WRITE.
  - There is no timeout. aes_done in any other state is ignored.
- WRITE: mst_req=1, mst_write=1, mst_addr=wr_ptr, mst_wdata=buffer word wcnt (same word mapping as READ).
  - Each ack: wr_ptr += 4, wcnt += 1.
  - After the 4th ack: blk_cnt -= 1. If blk_cnt == 0 -> FINISH, else -> READ.
- FINISH: done=1 for one cycle -> IDLE.
- Error: mst_ack && mst_err in READ or WRITE sets error, drops mst_req next cycle -> FINISH. The remaining blocks are abandoned.
- mst_addr, mst_write and mst_wdata stay stable while mst_req is high and mst_ack is low.
- Pointers wrap modulo 2^32 with no error.
- Latency, with ack every cycle and AES latency L: start at cycle 0; reads at cycles 1-4; aes_start at cycle 5; aes_done at 5+L; writes at 6+L..9+L; done pulse at 10+L for a 1-block job.

Decomposition:
- Package aes_acc_pkg: state enum, AES_BLOCK_W=128, WORD_W=32, NUM_WORDS=4, ADDR_INC=4.
- One sub-module, aes_word_buffer: a 4x32 register file with word-index write, 128-bit parallel load, 128-bit parallel read and word-index read.

Test Plan:
- Single block, src=0x1000, dst=0x2000, rdata 0x00112233/0x44556677/0x8899AABB/0xCCDDEEFF, ack every cycle, AES model L=10 -> aes_din=0x00112233_44556677_8899AABB_CCDDEEFF; writes to 0x2000, 0x2004, 0x2008, 0x200C; done at cycle 20.
- 3 blocks, random ack stalls of 0-3 cycles -> 12 reads over 0x1000-0x102C and 12 writes over 0x2000-0x202C; exactly one done pulse; busy high throughout.
- num_blocks=0 -> done pulse at cycle 1; mst_req and aes_start never assert.
- mst_err on the 2nd read ack of block 1 -> error=1, no aes_start, done pulse, IDLE. A later start clears error.
- start pulsed during WAIT -> ignored; counts and addresses unchanged.
- hrst asserted during WRITE word 2 -> next cycle all outputs 0 and state IDLE; a new start runs a clean job.
- src_addr=0xFFFFFFF8 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
